ca_gen_streamer: RTL and testbench
==================================

// Module: ca_gen_streamer
// PURPOSE
// - Downstream stage of the Rule 110 automaton. On request, it snapshots the
//   CELLS-bit state vector and streams it out as CELLS/W words over a
//   valid/ready handshake.
// - Tags each frame with its generation number, tracked in step with the
//   automaton's load.
// - Reports the frame's live-cell count and counts snapshot requests dropped while busy.
// PARAMETERS
// - CELLS  512  automaton width; must be an integer multiple of W
// - W      32   stream word width; BEATS = CELLS/W, must be >= 2
// - GEN_W  16   generation counter width
// PORTS
// - clk        in   1                      rising-edge clock, shared with the automaton
// - areset_n   in   1                      asynchronous active-low reset
// - load       in   1                      same load strobe that drives the automaton
// - q          in   CELLS                  automaton state, registered upstream
// - snap_req   in   1                      request one snapshot of q (single-cycle pulse)
// - m_data     out  W                      stream word
// - m_valid    out  1                      stream word valid
// - m_ready    in   1                      downstream ready
// - m_last     out  1                      final beat of the frame
// - m_gen      out  GEN_W                  generation of the frame; stable for the whole frame
// - busy       out  1                      high while in STREAM
// - frame_pop  out  $clog2(CELLS+1)        live cells in the last completed frame
// - frame_done out  1                      1-cycle pulse after the last beat is accepted
// - drop_cnt   out  8                      dropped snap_req count; saturates at 255
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - state = IDLE.
//   - gen_cnt, beat, pop_acc, frame_pop and drop_cnt = 0.
//   - m_valid, m_last, frame_done and busy = 0; m_data and m_gen = 0.
// - Generation counter (updates every edge):
//   - load = 1: gen_cnt <= 0.
//   - Otherwise: gen_cnt <= gen_cnt + 1, wrapping modulo 2^GEN_W.
//   - Result: gen_cnt always equals the generation currently held on q.
// - IDLE, snap_req = 1:
//   - Capture shadow <= q, m_gen <= gen_cnt, beat <= 0, pop_acc <= 0.
//   - Go to STREAM; m_valid rises on the next cycle.
//   - Latency: request to first valid beat is 1 cycle.
// - STREAM, word output:
//   - m_data = shadow[beat*W +: W]; beat 0 carries cells [W-1:0].
//   - m_last = (beat == BEATS-1).
// - STREAM, handshake:
//   - A beat transfers on m_valid && m_ready.
//   - m_data, m_last and m_gen hold stable while m_valid && !m_ready.
//   - m_valid never drops without a transfer.
// - STREAM, on each transfer:
//   - pop_acc += popcount(m_data).
//   - beat += 1.
// - STREAM, on the last-beat transfer:
//   - frame_pop <= pop_acc + popcount(m_data).
//   - frame_done pulses on the next cycle.
//   - Return to IDLE.
// - Back-to-back: snap_req in the same cycle as the last-beat transfer is
//   accepted. The new capture occurs that edge and STREAM restarts, so
//   m_valid stays high with beat = 0.
// - snap_req in STREAM (other than the last-beat transfer case) is dropped:
//   drop_cnt += 1, saturating at 255. The current frame is unaffected.
// - load during STREAM: resets gen_cnt only. The frame in flight and its m_gen
//   are unaffected, because the shadow is independent of q.
// - Async reset mid-frame: the frame is abandoned; m_valid = 0 immediately.
//   No frame_done is issued.
// - gen_cnt wrap: 2^GEN_W - 1 -> 0 with no flag.
// - No combinational path from m_ready to m_valid.
// STRUCTURE
// - ca_pkg holds:
//   - CELLS default (512).
//   - state typedef {IDLE, STREAM}.
//   - DROP_SAT = 8'hFF.
// - Sub-module popcount_w #(W): combinational popcount of one word, instanced
//   once on m_data. This avoids a CELLS-wide adder tree.
// - Top level contains: FSM, shadow register, beat counter, gen counter,
//   pop accumulator, drop counter.
// TESTING
// 1. Reset, load = 1 with data = 1 << 0, 3 idle cycles, snap_req, m_ready = 1.
//    Expect 16 beats, 1 per cycle; beat0 = 32'h1, beats 1-15 = 0; m_gen = 3.
//    Expect m_last on beat 15, frame_done one cycle later, frame_pop = 1.
// 2. All-ones q, snap_req, m_ready toggled 1/0 each cycle.
//    Expect m_data held across stalls, 16 transfers in 31 cycles, frame_pop = 512.
// 3. Three snap_req pulses mid-frame.
//    Expect drop_cnt = 3 and frame contents unchanged.
// 4. snap_req coincident with the last-beat transfer.
//    Expect m_valid to stay high, next beat0 = new q word0, and m_gen = gen_cnt
//    at that edge.
// 5. Assert areset_n = 0 at beat 7.
//    Expect m_valid = 0, busy = 0, drop_cnt = 0 and frame_pop = 0 immediately.
//    Expect no frame_done, and a clean first beat on the next snap_req.
// 6. Force gen_cnt to 16'hFFFF, then snap one cycle later.
//    Expect m_gen = 0; load mid-frame leaves m_gen unchanged.

Source files
------------

// File: rtl/ca_pkg.sv
// Shared constants and state encoding for the Rule 110 snapshot streamer.
package ca_pkg;

  localparam int CELLS_DEF = 512;
  localparam int W_DEF     = 32;
  localparam int GEN_W_DEF = 16;

  typedef logic [0:0] state_t;
  localparam state_t IDLE   = 1'b0;
  localparam state_t STREAM = 1'b1;

  localparam logic [7:0] DROP_SAT = 8'hFF;

endpackage

// File: rtl/popcount_w.sv
// Combinational population count of a single stream word.
module popcount_w #(
  parameter int W = 32
) (
  input  logic [W-1:0]           data,
  output logic [$clog2(W+1)-1:0] count
);

  localparam int CW = $clog2(W + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(data[i]);
    end
  end

endmodule

// File: rtl/ca_gen_streamer.sv
// Snapshots the automaton state on request and streams it as W-bit beats,
// tagged with the generation number and the frame's live-cell count.
module ca_gen_streamer
  import ca_pkg::*;
#(
  parameter int CELLS = CELLS_DEF,
  parameter int W     = W_DEF,
  parameter int GEN_W = GEN_W_DEF
) (
  input  logic                       clk,
  input  logic                       areset_n,
  input  logic                       load,
  input  logic [CELLS-1:0]           q,
  input  logic                       snap_req,
  output logic [W-1:0]               m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_last,
  output logic [GEN_W-1:0]           m_gen,
  output logic                       busy,
  output logic [$clog2(CELLS+1)-1:0] frame_pop,
  output logic                       frame_done,
  output logic [7:0]                 drop_cnt
);

  localparam int BEATS = CELLS / W;
  localparam int BW    = $clog2(BEATS);
  localparam int PW    = $clog2(CELLS + 1);
  localparam int CW    = $clog2(W + 1);

  if ((CELLS % W) != 0 || BEATS < 2) begin : g_bad_params
    $error("ca_gen_streamer: CELLS must be a multiple of W with at least 2 beats");
  end

  state_t           state;
  logic [CELLS-1:0] shadow;
  logic [BW-1:0]    beat;
  logic [GEN_W-1:0] gen_cnt;
  logic [PW-1:0]    pop_acc;
  logic [CW-1:0]    word_pop;
  logic             xfer;
  logic             last_xfer;
  logic             accept;

  // Outputs come straight from registers, so m_ready never reaches m_valid.
  assign m_valid   = (state == STREAM);
  assign busy      = m_valid;
  assign m_data    = shadow[int'(beat) * W +: W];
  assign m_last    = m_valid && (beat == BW'(BEATS - 1));

  assign xfer      = m_valid && m_ready;
  assign last_xfer = xfer && m_last;
  assign accept    = snap_req && ((state == IDLE) || last_xfer);

  popcount_w #(.W(W)) u_popcount (
    .data  (m_data),
    .count (word_pop)
  );

  // Tracks the generation on q: the automaton reloads on the same strobe.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      gen_cnt <= '0;
    end else if (load) begin
      gen_cnt <= '0;
    end else begin
      gen_cnt <= gen_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state      <= IDLE;
      shadow     <= '0;
      beat       <= '0;
      pop_acc    <= '0;
      frame_pop  <= '0;
      m_gen      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_xfer;
      if (last_xfer) begin
        frame_pop <= pop_acc + PW'(word_pop);
      end
      // A request on the closing beat restarts the stream without a gap.
      if (accept) begin
        state   <= STREAM;
        shadow  <= q;
        m_gen   <= gen_cnt;
        beat    <= '0;
        pop_acc <= '0;
      end else if (last_xfer) begin
        state   <= IDLE;
        beat    <= '0;
        pop_acc <= '0;
      end else if (xfer) begin
        beat    <= beat + 1'b1;
        pop_acc <= pop_acc + PW'(word_pop);
      end
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      drop_cnt <= '0;
    end else if (snap_req && (state == STREAM) && !last_xfer && (drop_cnt != DROP_SAT)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ca_gen_streamer.sv
// Directed self-checking bench for ca_gen_streamer (CELLS=512, W=32, GEN_W=16).
module tb_ca_gen_streamer;

  logic         clk;
  logic         areset_n;
  logic         load;
  logic [511:0] q;
  logic         snap_req;
  logic [31:0]  m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;
  logic [15:0]  m_gen;
  logic         busy;
  logic [9:0]   frame_pop;
  logic         frame_done;
  logic [7:0]   drop_cnt;

  int checks;
  int fails;

  logic [15:0] model_gen;
  logic [31:0] rx_words [16];
  int          rx_cnt;
  int          rx_cycles;
  int          rx_hold_err;
  int          rx_last_err;
  int          rx_gen_changed;
  int          rx_timeout;
  logic [15:0] rx_gen;
  logic [15:0] rx_snap_gen;

  ca_gen_streamer #(.CELLS(512), .W(32), .GEN_W(16)) dut (
    .clk        (clk),
    .areset_n   (areset_n),
    .load       (load),
    .q          (q),
    .snap_req   (snap_req),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .m_gen      (m_gen),
    .busy       (busy),
    .frame_pop  (frame_pop),
    .frame_done (frame_done),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference generation: zero on load, otherwise count every edge.
  always @(posedge clk or negedge areset_n) begin
    if (!areset_n) model_gen <= '0;
    else if (load) model_gen <= '0;
    else           model_gen <= model_gen + 16'd1;
  end

  // Drives one frame's handshake and records what was seen; tests judge the results.
  task automatic collect(input int ready_mode, input int n_drop, input bit snap_on_last,
                         input logic [511:0] next_q, input bit load_mid);
    logic [31:0] pd;
    logic        pl;
    bit          pstall;
    bit          done;
    int          cyc;
    rx_cnt = 0; rx_hold_err = 0; rx_last_err = 0; rx_gen_changed = 0; rx_timeout = 0;
    pstall = 0; done = 0; cyc = 0; pd = '0; pl = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      snap_req = 1'b0;
      load = 1'b0;
      if (cyc == 0) rx_gen = m_gen;
      else if (m_gen !== rx_gen) rx_gen_changed++;
      if (pstall && (m_data !== pd || m_last !== pl || m_valid !== 1'b1)) rx_hold_err++;
      m_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      if (cyc >= 2 && cyc < 2 + 2 * n_drop && (cyc % 2) == 0) snap_req = 1'b1;
      if (load_mid && cyc == 3) load = 1'b1;
      if (m_valid && m_ready) begin
        if (m_last !== (rx_cnt == 15)) rx_last_err++;
        if (rx_cnt < 16) rx_words[rx_cnt] = m_data;
        rx_cnt++;
        if (m_last || rx_cnt >= 16) begin
          done = 1;
          if (snap_on_last) begin
            snap_req    = 1'b1;
            q           = next_q;
            rx_snap_gen = model_gen;
          end
        end
      end
      pstall = m_valid && !m_ready;
      pd = m_data;
      pl = m_last;
      cyc++;
    end
    rx_cycles = cyc;
    if (!done) rx_timeout = 1;
  endtask

  task automatic test_reset();
    areset_n = 1'b0; load = 1'b0; q = '0; snap_req = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid got %b want 0", m_valid); end
    checks++; if (busy !== 1'b0 || m_last !== 1'b0 || frame_done !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_flags got busy=%b last=%b done=%b want 0", busy, m_last, frame_done); end
    checks++; if (m_data !== 32'h0 || m_gen !== 16'h0) begin
      fails++; $display("[TB] FAIL reset_data got data=%h gen=%h want 0", m_data, m_gen); end
    checks++; if (frame_pop !== 10'd0 || drop_cnt !== 8'd0) begin
      fails++; $display("[TB] FAIL reset_counts got pop=%0d drop=%0d want 0", frame_pop, drop_cnt); end
    areset_n = 1'b1;
  endtask

  task automatic test_single_bit();
    @(negedge clk); load = 1'b1; q = 512'h1;
    @(negedge clk); load = 1'b0;
    repeat (3) @(negedge clk);
    snap_req = 1'b1;
    collect(0, 0, 0, '0, 0);
    checks++; if (rx_timeout != 0 || rx_cycles != 16) begin
      fails++; $display("[TB] FAIL t1_cycles got %0d want 16", rx_cycles); end
    checks++; if (rx_words[0] !== 32'h1) begin fails++; $display("[TB] FAIL t1_beat0 got %h want 00000001", rx_words[0]); end
    for (int i = 1; i < 16; i++) begin
      checks++; if (rx_words[i] !== 32'h0) begin fails++; $display("[TB] FAIL t1_beat%0d got %h want 0", i, rx_words[i]); end
    end
    checks++; if (rx_last_err != 0) begin fails++; $display("[TB] FAIL t1_last got %0d errors want 0", rx_last_err); end
    checks++; if (rx_gen !== 16'd3) begin fails++; $display("[TB] FAIL t1_gen got %0d want 3", rx_gen); end
    @(negedge clk);
    checks++; if (frame_done !== 1'b1 || m_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL t1_done got done=%b valid=%b want 1/0", frame_done, m_valid); end
    checks++; if (frame_pop !== 10'd1) begin fails++; $display("[TB] FAIL t1_pop got %0d want 1", frame_pop); end
    @(negedge clk);
    checks++; if (frame_done !== 1'b0) begin fails++; $display("[TB] FAIL t1_done_pulse got %b want 0", frame_done); end
  endtask

  task automatic test_backpressure();
    int bad;
    @(negedge clk); q = '1; snap_req = 1'b1;
    collect(1, 0, 0, '0, 0);
    checks++; if (rx_timeout != 0 || rx_cycles != 31) begin
      fails++; $display("[TB] FAIL t2_cycles got %0d want 31", rx_cycles); end
    checks++; if (rx_hold_err != 0) begin fails++; $display("[TB] FAIL t2_hold got %0d errors want 0", rx_hold_err); end
    bad = 0;
    for (int i = 0; i < 16; i++) if (rx_words[i] !== 32'hFFFF_FFFF) bad++;
    checks++; if (bad != 0) begin fails++; $display("[TB] FAIL t2_words got %0d bad words want 0", bad); end
    @(negedge clk);
    checks++; if (frame_pop !== 10'd512) begin fails++; $display("[TB] FAIL t2_pop got %0d want 512", frame_pop); end
  endtask

  task automatic test_drop();
    logic [511:0] exp_q;
    int bad;
    for (int i = 0; i < 16; i++) exp_q[i*32 +: 32] = 32'hA500_0000 + 32'(i * 3);
    @(negedge clk); q = exp_q; snap_req = 1'b1;
    @(negedge clk); snap_req = 1'b0; q = '0; m_ready = 1'b0;
    collect(0, 3, 0, '0, 0);
    bad = 0;
    for (int i = 0; i < 16; i++) if (rx_words[i] !== exp_q[i*32 +: 32]) bad++;
    checks++; if (rx_timeout != 0 || bad != 0) begin fails++; $display("[TB] FAIL t3_words got %0d bad words want 0", bad); end
    checks++; if (drop_cnt !== 8'd3) begin fails++; $display("[TB] FAIL t3_drop got %0d want 3", drop_cnt); end
    @(negedge clk);
    checks++; if (frame_pop !== 10'($countones(exp_q))) begin
      fails++; $display("[TB] FAIL t3_pop got %0d want %0d", frame_pop, $countones(exp_q)); end
  endtask

  task automatic test_back_to_back();
    logic [511:0] qa;
    logic [511:0] qb;
    logic [15:0]  exp_gen;
    int bad;
    for (int i = 0; i < 16; i++) begin
      qa[i*32 +: 32] = 32'h1111_0000 | 32'(i);
      qb[i*32 +: 32] = 32'h2222_0000 | 32'(i + 16);
    end
    @(negedge clk); q = qa; snap_req = 1'b1;
    collect(0, 0, 1, qb, 0);
    exp_gen = rx_snap_gen;
    collect(0, 0, 0, '0, 0);
    checks++; if (rx_timeout != 0 || rx_cycles != 16) begin
      fails++; $display("[TB] FAIL t4_no_gap got %0d cycles want 16", rx_cycles); end
    checks++; if (rx_words[0] !== qb[31:0]) begin fails++; $display("[TB] FAIL t4_beat0 got %h want %h", rx_words[0], qb[31:0]); end
    bad = 0;
    for (int i = 1; i < 16; i++) if (rx_words[i] !== qb[i*32 +: 32]) bad++;
    checks++; if (bad != 0) begin fails++; $display("[TB] FAIL t4_words got %0d bad words want 0", bad); end
    checks++; if (rx_gen !== exp_gen) begin fails++; $display("[TB] FAIL t4_gen got %0d want %0d", rx_gen, exp_gen); end
    checks++; if (drop_cnt !== 8'd3) begin fails++; $display("[TB] FAIL t4_drop got %0d want 3", drop_cnt); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    logic [511:0] qc;
    int seen;
    for (int i = 0; i < 16; i++) qc[i*32 +: 32] = 32'hC0DE_0000 | 32'(i);
    @(negedge clk); q = qc; snap_req = 1'b1; m_ready = 1'b1;
    @(negedge clk); snap_req = 1'b0;
    repeat (7) @(negedge clk);
    checks++; if (m_data !== qc[7*32 +: 32]) begin fails++; $display("[TB] FAIL t5_beat7 got %h want %h", m_data, qc[7*32 +: 32]); end
    areset_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("[TB] FAIL t5_abort got valid=%b busy=%b want 0", m_valid, busy); end
    checks++; if (drop_cnt !== 8'd0 || frame_pop !== 10'd0) begin
      fails++; $display("[TB] FAIL t5_counts got drop=%0d pop=%0d want 0", drop_cnt, frame_pop); end
    @(negedge clk); areset_n = 1'b1;
    seen = 0;
    repeat (3) begin @(negedge clk); if (frame_done !== 1'b0) seen++; end
    checks++; if (seen != 0) begin fails++; $display("[TB] FAIL t5_no_done got %0d pulses want 0", seen); end
    q = ~qc; snap_req = 1'b1;
    collect(0, 0, 0, '0, 0);
    checks++; if (rx_timeout != 0 || rx_cycles != 16 || rx_words[0] !== ~qc[31:0]) begin
      fails++; $display("[TB] FAIL t5_restart got cycles=%0d beat0=%h want 16/%h", rx_cycles, rx_words[0], ~qc[31:0]); end
    @(negedge clk);
  endtask

  task automatic test_gen_wrap();
    int n;
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
    n = 0;
    while (model_gen != 16'hFFFF && n < 70000) begin @(negedge clk); n++; end
    checks++; if (model_gen != 16'hFFFF) begin fails++; $display("[TB] FAIL t6_wait got gen %h want ffff", model_gen); end
    @(negedge clk);
    q = 512'hF0; snap_req = 1'b1;
    collect(0, 0, 0, '0, 1);
    checks++; if (rx_gen !== 16'h0) begin fails++; $display("[TB] FAIL t6_wrap_gen got %h want 0000", rx_gen); end
    checks++; if (rx_gen_changed != 0 || rx_timeout != 0) begin
      fails++; $display("[TB] FAIL t6_gen_stable got %0d changes want 0", rx_gen_changed); end
    checks++; if (rx_words[0] !== 32'hF0) begin fails++; $display("[TB] FAIL t6_beat0 got %h want 000000f0", rx_words[0]); end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_single_bit();
    test_backpressure();
    test_drop();
    test_back_to_back();
    test_abort();
    test_gen_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
